fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
Instruction fetch stage placed directly upstream of the single-cycle datapath; it replaces the direct PC-to-instruction-memory path. It owns the fetch PC, issues sequential word requests to a pipelined instruction memory with variable response latency, and buffers responses in a small FIFO. It presents {instruction, pc} to the datapath with a valid/ready handshake. Taken branches and jumps from the datapath's next-PC mux arrive as redirects, which flush the FIFO and discard stale in-flight responses.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, FIFO entries; also the credit limit on (FIFO occupancy + requests in flight); power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  word-aligned fetch address
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  response valid; responses return in request order, >= 1 cycle after acceptance
imem_rsp_data  in  XLEN  fetched instruction word
redirect_valid  in  1  taken branch/jump from datapath
redirect_pc  in  XLEN  new fetch target
inst_valid  out  1  FIFO head valid
inst_data  out  XLEN  head instruction
inst_pc  out  XLEN  address of head instruction
inst_ready  in  1  datapath consumes head this cycle

Behaviour:
- Reset (rst==0 at edge): fetch_pc=RESET_PC, FIFO empty, inflight=0, discard=0, state=FETCH; imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0. First request is driven combinationally in the first cycle with rst==1.
- Reset mid-operation: all counters cleared; any later responses to pre-reset requests are the memory's responsibility (memory is reset on the same rst).
- States: FETCH, FLUSH.
  - FETCH: imem_req_valid = (fifo_count + inflight < DEPTH). The request is accepted when valid&&ready: fetch_pc += 4 (mod 2^XLEN, 32'hFFFF_FFFC wraps to 0) and inflight++. A response with discard==0 is pushed as {imem_rsp_data, pc}, inflight--. The pc is tracked by a separate rsp_pc register, +4 per accepted response.
  - Redirect (any state): fetch_pc and rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00}. FIFO is flushed. discard <= inflight (minus 1 if a response arrives the same cycle, plus 1 if a request is accepted the same cycle). No request is issued in the redirect cycle. Next state = FLUSH if that discard value is > 0, else FETCH.
  - FLUSH: imem_req_valid=0. Each response decrements discard and inflight and is dropped. Move to FETCH when discard reaches 0; requests resume the following cycle.
- Handshake: the head is popped when inst_valid&&inst_ready. inst_valid/data/pc are stable until popped. Simultaneous push and pop at full occupancy is legal.
- Simultaneous redirect and pop: the popped instruction counts as consumed; redirect flushes the rest.
- Simultaneous redirect and response: the response is discarded.
- Minimum latency: request accepted in cycle N, response in N+1, inst_valid in N+2 (FIFO registered, no bypass).
- Throughput: with 1-cycle memory and inst_ready held high, one instruction per cycle sustained.
- Credit rule guarantees no FIFO overflow; a push to a full FIFO is a design error (assertion).

Test Plan:
- Reset/startup: hold rst=0 5 cycles, release; 1-cycle memory returning addr-encoded words -> req addrs 0,4,8,...; first inst_valid 2 cycles after first accept with inst_pc=0; then 1 instr/cycle.
- Backpressure: inst_ready=0 for 10 cycles -> at most DEPTH outstanding+buffered; imem_req_valid drops; no loss or duplication; order 0,4,8,12 preserved on release.
- Redirect with 3 in flight (3-cycle memory latency): redirect_pc=0x100 -> FSM enters FLUSH, 3 responses dropped, next delivered inst_pc=0x100, then 0x104.
- Corner collisions: redirect coincident with a response and with a pop -> response dropped, popped instr delivered once, discard count correct, next inst_pc = target.
- Misaligned/wrap: redirect_pc=0xFFFF_FFFA -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-stream: assert rst=0 during FLUSH -> all outputs return to reset values next edge; restart fetches from RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit_if.sv
// Signal bundle between the fetch unit, the pipelined instruction memory and the datapath.
// The master modport is the fetch unit; the slave modport is the memory/datapath side.
interface fetch_prefetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;
   logic            inst_ready;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: credit-limited sequential prefetch into a small FIFO, with
// redirect-driven flush that drops responses to requests issued before the redirect.
module fetch_prefetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input logic                   clk,
   input logic                   rst,
   fetch_prefetch_unit_if.master bus
);

   typedef enum logic {
      ST_FETCH,
      ST_FLUSH
   } state_e;

   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
   localparam logic [XLEN-1:0] WORD    = XLEN'(4);

   state_e          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0] data_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];

   logic [XLEN-1:0] target;
   logic            credit_ok;
   logic            req_valid;
   logic            req_fire;
   logic            rsp_fire;
   logic            head_valid;
   logic            push;
   logic            pop;
   logic            unused_redirect_lsb;

   assign target              = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

   // Buffered entries plus outstanding requests never exceed DEPTH, so a response always has a slot.
   assign credit_ok  = ({1'b0, count_q} + {1'b0, inflight_q}) < CREDITS;
   assign req_valid  = rst && (state_q == ST_FETCH) && !bus.redirect_valid && credit_ok;
   assign req_fire   = req_valid && bus.imem_req_ready;
   assign rsp_fire   = bus.imem_rsp_valid;
   assign head_valid = (count_q != '0);
   assign pop        = head_valid && bus.inst_ready;
   assign push       = rsp_fire && (state_q == ST_FETCH) && !bus.redirect_valid;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (bus.redirect_valid) begin
         // Everything still outstanding after this cycle belongs to the old path.
         fetch_pc_d = target;
         rsp_pc_d   = target;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         discard_d  = inflight_d;
         state_d    = (inflight_d != '0) ? ST_FLUSH : ST_FETCH;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + WORD;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + WORD;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
         if ((state_q == ST_FLUSH) && rsp_fire) begin
            discard_d = discard_q - CW'(1);
            if (discard_q == CW'(1)) begin
               state_d = ST_FETCH;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // NOTE: FIFO storage is not reset; the count gates validity and the outputs below read zero when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
         pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.inst_valid     = head_valid;
   assign bus.inst_data      = head_valid ? data_mem_q[rd_ptr_q] : '0;
   assign bus.inst_pc        = head_valid ? pc_mem_q[rd_ptr_q] : '0;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(push && (count_q == FULL) && !pop));

   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst)
      !(rsp_fire && (inflight_q == '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: in-order variable-latency memory model returning ~addr,
// a delivery monitor tracking the expected PC stream, and hand-timed cycle checks.
module tb_fetch_prefetch_unit;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   lat   = 1;
   int   mem_cyc = 0;
   int   acc_cnt = 0;
   int   del_cnt = 0;
   int   snap;
   logic [31:0] exp_pc = 32'h0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend_q[$];
   pend_t head;

   fetch_prefetch_unit_if #(.XLEN(32)) bus ();

   fetch_prefetch_unit #(
      .XLEN    (32),
      .DEPTH   (4),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Memory: responses in request order, no earlier than `lat` cycles after acceptance.
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         mem_cyc++;
         if (pend_q.size() != 0 && pend_q[0].due <= mem_cyc) begin
            head = pend_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ~head.addr;
         end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
         end
         #4;
         if (!rst) begin
            pend_q.delete();
         end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend_q.push_back('{addr: bus.imem_req_addr, due: mem_cyc + lat});
         end
      end
   end

   // Delivery monitor: every consumed instruction must be the next PC on the current path.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!rst) begin
            exp_pc = 32'h0;
         end else begin
            if (bus.inst_valid && bus.inst_ready) begin
               check("seq_pc", bus.inst_pc, exp_pc);
               check("seq_data", bus.inst_data, ~exp_pc);
               exp_pc = exp_pc + 32'd4;
               del_cnt++;
            end
            if (bus.redirect_valid) begin
               exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               acc_cnt++;
            end
         end
      end
   end

   task automatic drain();
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      check("drain_empty", bus.inst_valid, 1'b0);
   endtask

   initial begin
      rst                = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b1;

      // Reset held for 5 cycles
      repeat (5) @(negedge clk);
      #1;
      check("rst_inst_valid", bus.inst_valid, 1'b0);
      check("rst_inst_data", bus.inst_data, 32'h0);
      check("rst_inst_pc", bus.inst_pc, 32'h0);
      check("rst_req_valid", bus.imem_req_valid, 1'b0);

      // Startup with 1-cycle memory
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("start_req_valid", bus.imem_req_valid, 1'b1);
      check("start_req_addr", bus.imem_req_addr, 32'h0);
      check("start_inst_valid", bus.inst_valid, 1'b0);
      @(negedge clk);
      #1;
      check("start_req_addr1", bus.imem_req_addr, 32'h4);
      check("lat_inst_valid", bus.inst_valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         check("stream_valid", bus.inst_valid, 1'b1);
         check("stream_pc", bus.inst_pc, 32'(i * 4));
      end

      // Backpressure: 10 stalled cycles fill FIFO with 24..36, requests stop at the credit limit
      @(negedge clk);
      bus.inst_ready = 1'b0;
      #1;
      check("stall_head_pc", bus.inst_pc, 32'd24);
      repeat (9) @(negedge clk);
      #1;
      check("stall_req_valid", bus.imem_req_valid, 1'b0);
      check("stall_inst_valid", bus.inst_valid, 1'b1);
      check("stall_head_hold", bus.inst_pc, 32'd24);
      check("stall_accepted", 32'(acc_cnt), 32'd10);
      check("stall_delivered", 32'(del_cnt), 32'd6);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.inst_ready = 1'b1;
         #1;
         check("release_pc", bus.inst_pc, 32'(24 + i * 4));
      end

      // Redirect with 3 requests in flight; latency 4 keeps responses clear of the redirect cycle
      drain();
      lat = 4;
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      #1;
      check("rd_req_valid", bus.imem_req_valid, 1'b1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      #1;
      check("rd_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      check("flush_req", bus.imem_req_valid, 1'b0);
      check("flush_inst", bus.inst_valid, 1'b0);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("flush_req", bus.imem_req_valid, 1'b0);
      end
      @(negedge clk);
      #1;
      check("resume_valid", bus.imem_req_valid, 1'b1);
      check("resume_addr", bus.imem_req_addr, 32'h100);
      repeat (3) @(negedge clk);
      @(negedge clk);
      #1;
      check("rd_lat", bus.inst_valid, 1'b0);
      @(negedge clk);
      #1;
      check("rd_first_valid", bus.inst_valid, 1'b1);
      check("rd_first_pc", bus.inst_pc, 32'h100);
      check("rd_first_data", bus.inst_data, 32'hFFFF_FEFF);
      @(negedge clk);
      #1;
      check("rd_second_pc", bus.inst_pc, 32'h104);

      // Redirect coinciding with a response and a pop (1-cycle memory, steady stream)
      drain();
      lat = 1;
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      #1;
      snap = del_cnt;
      check("coll_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      check("coll_req_valid", bus.imem_req_valid, 1'b1);
      check("coll_req_addr", bus.imem_req_addr, 32'h200);
      check("coll_flushed", bus.inst_valid, 1'b0);
      @(negedge clk);
      #1;
      check("coll_empty", bus.inst_valid, 1'b0);
      @(negedge clk);
      #1;
      check("coll_pop_once", 32'(del_cnt - snap), 32'd1);
      check("coll_valid", bus.inst_valid, 1'b1);
      check("coll_pc", bus.inst_pc, 32'h200);
      @(negedge clk);
      #1;
      check("coll_pc1", bus.inst_pc, 32'h204);

      // 3-cycle memory: redirect meets the first of 3 responses, leaving 2 to discard
      drain();
      lat = 3;
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h300;
      #1;
      check("dis_no_req", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      #1;
      check("dis_flush0", bus.imem_req_valid, 1'b0);
      check("dis_dropped", bus.inst_valid, 1'b0);
      @(negedge clk);
      #1;
      check("dis_flush1", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      #1;
      check("dis_resume", bus.imem_req_valid, 1'b1);
      check("dis_addr", bus.imem_req_addr, 32'h300);
      repeat (3) @(negedge clk);
      @(negedge clk);
      #1;
      check("dis_valid", bus.inst_valid, 1'b1);
      check("dis_pc", bus.inst_pc, 32'h300);

      // Misaligned target near the top of the address space wraps to zero
      drain();
      lat = 1;
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFA;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      check("wrap_req_valid", bus.imem_req_valid, 1'b1);
      check("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      #1;
      check("wrap_addr1", bus.imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      check("wrap_addr2", bus.imem_req_addr, 32'h0);
      check("wrap_pc0", bus.inst_pc, 32'hFFFF_FFF8);
      @(negedge clk);
      #1;
      check("wrap_pc1", bus.inst_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      check("wrap_pc2", bus.inst_pc, 32'h0);

      // Reset asserted while flushing
      drain();
      lat = 4;
      @(negedge clk);
      bus.imem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h400;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      #1;
      check("mid_flush", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      lat = 1;
      #1;
      check("mid_rst_inst_valid", bus.inst_valid, 1'b0);
      check("mid_rst_inst_data", bus.inst_data, 32'h0);
      check("mid_rst_inst_pc", bus.inst_pc, 32'h0);
      check("mid_rst_req_valid", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("restart_req_valid", bus.imem_req_valid, 1'b1);
      check("restart_addr", bus.imem_req_addr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("restart_valid", bus.inst_valid, 1'b1);
      check("restart_pc", bus.inst_pc, 32'h0);
      check("restart_data", bus.inst_data, 32'hFFFF_FFFF);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
